rr_timeout_arbiter: RTL and testbench

- Parametrised round-robin arbiter for N router input ports. Each port has a packet-length-based grant timeout.
- Successor of the fixed 5-port L/N/E/W/S arbiter: the port count and field widths are generic, priority rotates from the last granted port, and grant, index and timeout events are exposed as registered outputs.
- Sits in front of the router crossbar. It drives crossbar select and per-input read enables.

---
 rtl/rr_timeout_arbiter.sv | 137 +++++++++++++
 tb/tb_rr_timeout_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/rr_timeout_arbiter.sv
// Round-robin arbiter for NPORTS router inputs with per-port, header-loaded grant timeouts.
// Optional `ARB_STATS_EN adds saturating timeout / new-grant event counters.
module rr_timeout_arbiter #(
  parameter int NPORTS    = 5,
  parameter int LEN_W     = 12,
  parameter int FID_W     = 3,
  parameter int HEADER_ID = 1,
  parameter int IDX_W     = $clog2(NPORTS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NPORTS-1:0]         req,
  input  logic [NPORTS*FID_W-1:0]   flit_id,
  input  logic [NPORTS*LEN_W-1:0]   length,
  output logic [NPORTS-1:0]         grant,
  output logic                      grant_valid,
  output logic [IDX_W-1:0]          grant_idx,
  output logic                      timeout
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]               timeout_cnt,
  output logic [15:0]               grant_cnt
`endif
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state, state_nxt;
  logic [LEN_W-1:0]   limit [NPORTS];
  logic [IDX_W-1:0]   ptr, ptr_nxt;
  logic [LEN_W-1:0]   count, count_nxt;
  logic [LEN_W:0]     count_inc;
  logic [NPORTS-1:0]  grant_nxt;
  logic [NPORTS-1:0]  cand;
  logic [IDX_W-1:0]   idx_nxt;
  logic [IDX_W:0]     pick_res;
  logic               timeout_nxt;
  logic               new_grant;
  logic               expire;

  // Returns {found, index} of the first set bit of r searching p+1, p+2, ... modulo NPORTS.
  function automatic logic [IDX_W:0] pick(input logic [NPORTS-1:0] r, input logic [IDX_W-1:0] p);
    logic [IDX_W:0] res;
    int             c;
    res = '0;
    for (int k = NPORTS; k >= 1; k--) begin
      c = (int'(p) + k) % NPORTS;
      if (r[c]) res = {1'b1, IDX_W'(c)};
    end
    return res;
  endfunction

  for (genvar i = 0; i < NPORTS; i++) begin : g_limit
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) limit[i] <= '0;
      else if (flit_id[i*FID_W +: FID_W] == FID_W'(HEADER_ID)) limit[i] <= length[i*LEN_W +: LEN_W];
    end
  end

  // In GRANT the registered grant is the owner's one-hot, so masking it excludes the owner.
  assign cand      = req & ~grant;
  assign pick_res  = pick(cand, ptr);
  assign count_inc = {1'b0, count} + {{LEN_W{1'b0}}, 1'b1};
  assign expire    = (state == GRANT) && req[ptr] && (limit[ptr] != '0) &&
                     (count_inc >= {1'b0, limit[ptr]});

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    count_nxt   = count;
    grant_nxt   = grant;
    idx_nxt     = grant_idx;
    timeout_nxt = 1'b0;
    new_grant   = 1'b0;
    case (state)
      IDLE: begin
        if (pick_res[IDX_W]) new_grant = 1'b1;
      end
      GRANT: begin
        if (!req[ptr] || expire) begin
          timeout_nxt = expire;
          if (pick_res[IDX_W]) begin
            new_grant = 1'b1;
          end else begin
            state_nxt = IDLE;
            grant_nxt = '0;
            idx_nxt   = '0;
          end
        end else if (!(&count)) begin
          count_nxt = count + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (new_grant) begin
      state_nxt          = GRANT;
      ptr_nxt            = pick_res[IDX_W-1:0];
      count_nxt          = '0;
      grant_nxt          = '0;
      grant_nxt[ptr_nxt] = 1'b1;
      idx_nxt            = ptr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ptr         <= IDX_W'(NPORTS - 1);
      count       <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      count       <= count_nxt;
      grant       <= grant_nxt;
      grant_valid <= |grant_nxt;
      grant_idx   <= idx_nxt;
      timeout     <= timeout_nxt;
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timeout_cnt <= '0;
      grant_cnt   <= '0;
    end else begin
      if (timeout_nxt && timeout_cnt != 16'hFFFF) timeout_cnt <= timeout_cnt + 16'd1;
      if (new_grant && grant_cnt != 16'hFFFF)     grant_cnt   <= grant_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rr_timeout_arbiter.sv
// Directed testbench for rr_timeout_arbiter (default parameters, 5 ports).
// Stats checks compile in only when ARB_STATS_EN is defined.
module tb_rr_timeout_arbiter;
  localparam int NPORTS = 5;
  localparam int LEN_W  = 12;
  localparam int FID_W  = 3;
  localparam int IDX_W  = 3;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic [NPORTS-1:0]        req = '0;
  logic [NPORTS*FID_W-1:0]  flit_id = '0;
  logic [NPORTS*LEN_W-1:0]  length = '0;
  logic [NPORTS-1:0]        grant;
  logic                     grant_valid;
  logic [IDX_W-1:0]         grant_idx;
  logic                     timeout;
`ifdef ARB_STATS_EN
  logic [15:0]              timeout_cnt;
  logic [15:0]              grant_cnt;
`endif

  int total = 0;
  int bad   = 0;

  rr_timeout_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .flit_id     (flit_id),
    .length      (length),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .timeout     (timeout)
`ifdef ARB_STATS_EN
    ,
    .timeout_cnt (timeout_cnt),
    .grant_cnt   (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Advance one rising edge; outputs are then stable and inputs may change.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req     = '0;
    flit_id = '0;
    length  = '0;
    rst     = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic set_header(input int port, input int len);
    flit_id[port*FID_W +: FID_W] = 3'd1;
    length[port*LEN_W +: LEN_W]  = LEN_W'(len);
  endtask

  task automatic check_out(input string name, input logic [NPORTS-1:0] exp_g, input logic exp_to);
    logic [IDX_W-1:0] exp_idx;
    exp_idx = '0;
    for (int i = 0; i < NPORTS; i++) if (exp_g[i]) exp_idx = IDX_W'(i);
    total++;
    if (grant !== exp_g || grant_valid !== (|exp_g) || grant_idx !== exp_idx || timeout !== exp_to) begin
      bad++;
      $display("FAIL %s: grant=%b valid=%b idx=%0d timeout=%b expected grant=%b valid=%b idx=%0d timeout=%b",
               name, grant, grant_valid, grant_idx, timeout, exp_g, |exp_g, exp_idx, exp_to);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    check_out("reset_initial", 5'b00000, 1'b0);
    rst = 1'b1;
    step();
    req = 5'b00001;
    step();
    check_out("reset_pre_grant", 5'b00001, 1'b0);
    #2 rst = 1'b0;
    #1;
    check_out("reset_async", 5'b00000, 1'b0);
    req = '0;
    step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_out("reset_idle", 5'b00000, 1'b0);
    end
  endtask

  task automatic test_rotation();
    int exp_seq[6] = '{0, 1, 2, 3, 4, 0};
    do_reset();
    req = 5'b11111;
    step();
    for (int i = 0; i < 6; i++) begin
      check_out($sformatf("rotation_%0d", i), 5'b00001 << exp_seq[i], 1'b0);
      req = 5'b11111 & ~(5'b00001 << exp_seq[i]);
      step();
    end
    req = '0;
  endtask

  task automatic test_timeout();
    do_reset();
    set_header(2, 4);
    step();
    flit_id = '0;
    req = 5'b01100;
    for (int i = 0; i < 4; i++) begin
      step();
      check_out($sformatf("timeout_hold_%0d", i), 5'b00100, 1'b0);
    end
    step();
    check_out("timeout_handover", 5'b01000, 1'b1);
    step();
    check_out("timeout_pulse_end", 5'b01000, 1'b0);
    req = '0;
  endtask

  task automatic test_sole_timeout();
    do_reset();
    set_header(1, 3);
    step();
    flit_id = '0;
    req = 5'b00010;
    for (int i = 0; i < 3; i++) begin
      step();
      check_out($sformatf("sole_hold_%0d", i), 5'b00010, 1'b0);
    end
    step();
    check_out("sole_idle", 5'b00000, 1'b1);
    step();
    check_out("sole_regrant", 5'b00010, 1'b0);
    req = '0;
  endtask

  task automatic test_limit_change();
    do_reset();
    set_header(0, 10);
    step();
    flit_id = '0;
    req = 5'b00001;
    for (int i = 0; i < 5; i++) begin
      step();
      check_out($sformatf("lchg_hold_%0d", i), 5'b00001, 1'b0);
    end
    // count is 4 here; the new limit lands as count reaches 5.
    set_header(0, 4);
    step();
    flit_id = '0;
    check_out("lchg_count5", 5'b00001, 1'b0);
    step();
    check_out("lchg_expire", 5'b00000, 1'b1);
    step();
    check_out("lchg_regrant", 5'b00001, 1'b0);
    req = '0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    req = 5'b10001;
    step();
    check_out("b2b_first", 5'b00001, 1'b0);
    req = 5'b10000;
    step();
    check_out("b2b_handover", 5'b10000, 1'b0);
    req = 5'b00000;
    step();
    check_out("b2b_release_idle", 5'b00000, 1'b0);
  endtask

`ifdef ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    set_header(2, 4);
    step();
    flit_id = '0;
    for (int run = 0; run < 2; run++) begin
      req = 5'b01100;
      for (int i = 0; i < 7; i++) step();
      req = '0;
      step();
    end
    total++;
    if (timeout_cnt !== 16'd2) begin
      bad++;
      $display("FAIL stats_timeout_cnt: got %0d expected 2", timeout_cnt);
    end
    total++;
    if (grant_cnt !== 16'd4) begin
      bad++;
      $display("FAIL stats_grant_cnt: got %0d expected 4", grant_cnt);
    end
    set_header(0, 1);
    set_header(1, 1);
    step();
    flit_id = '0;
    req = 5'b00011;
    for (int i = 0; i < 70000; i++) step();
    req = '0;
    step();
    total++;
    if (timeout_cnt !== 16'hFFFF) begin
      bad++;
      $display("FAIL stats_timeout_sat: got %0h expected ffff", timeout_cnt);
    end
    total++;
    if (grant_cnt !== 16'hFFFF) begin
      bad++;
      $display("FAIL stats_grant_sat: got %0h expected ffff", grant_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_rotation();
    test_timeout();
    test_sole_timeout();
    test_limit_change();
    test_back_to_back();
`ifdef ARB_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
